// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
//
// Decides when the alarm fires, drives the buzzer, and handles snooze, stop
// and the automatic ring timeout. The committed alarm time is compared with
// the running time-of-day. An alarm fires once per equality episode, on the
// rising edge of the registered match.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : SNOOZE state and snooze counter are built.
//   undefined : snooze_pulse is ignored, and snoozing/snooze_left are tied to 0.
//
// Parameters:
//   RING_SECONDS   seconds the alarm rings before stopping by itself (1..511)
//   SNOOZE_SECONDS seconds of silence after a snooze (1..511)
//   MAX_SNOOZE     snoozes allowed per alarm event (1..7)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tick_1hz       one-cycle pulse once per second
//   current_time   BCD hh:mm:ss time of day
//   intended_alarm BCD hh:mm:ss alarm time; 0 means no alarm set
//   alarm_enable   level switch; low forces IDLE
//   snooze_pulse   one-cycle snooze request
//   stop_pulse     one-cycle stop request
//   buzzer         piezo drive (1 s on / 1 s off while ringing)
//   ringing        high in RINGING
//   snoozing       high in SNOOZE
//   snooze_left    snoozes remaining for the current event
//
// Request semantics: tick_1hz, snooze_pulse and stop_pulse are single-cycle
// strobes with no handshake. Each one is acted on in the cycle it is high,
// and there is no back-pressure. Priority is:
//   alarm_enable low > stop > accepted snooze > tick.
//
// All outputs are registered. They are computed from the next-state values,
// so they change on the same edge as the state, with no extra cycle of delay.
// -----------------------------------------------------------------------------
module alarm_trigger #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [23:0] current_time,
  input  logic [23:0] intended_alarm,
  input  logic        alarm_enable,
  input  logic        snooze_pulse,
  input  logic        stop_pulse,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozing,
  output logic [2:0]  snooze_left
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZE  = 2'd2;

  localparam logic [8:0] RING_LOAD   = 9'(RING_SECONDS);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECONDS);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [8:0] sec_cnt;
  logic [8:0] sec_cnt_nxt;
  logic [8:0] sec_cnt_dec;
  logic       beep_phase;
  logic       beep_phase_nxt;
  logic       match;
  logic       match_q;
  logic       fire;
  logic       last_tick;

  // The alarm is only armed when it is enabled and an alarm time is set.
  assign match = alarm_enable && (intended_alarm != 24'h000000) &&
                 (current_time == intended_alarm);
  assign fire  = match && !match_q;

  // sec_cnt saturates at zero and never wraps.
  assign sec_cnt_dec = (sec_cnt != 9'd0) ? (sec_cnt - 9'd1) : 9'd0;
  // This tick takes the count to zero, so the current phase ends here.
  assign last_tick   = tick_1hz && (sec_cnt <= 9'd1);

`ifdef ALARM_SNOOZE_EN
  logic [2:0] snooze_left_nxt;
  logic       snooze_ok;

  // A snooze with no snoozes remaining is simply not accepted. In that case
  // a coincident tick still takes effect.
  assign snooze_ok = snooze_pulse && (snooze_left != 3'd0);
`else
  logic [14:0] unused_snooze;
  assign unused_snooze = {snooze_pulse, SNOOZE_LOAD, SNOOZE_MAX, ST_SNOOZE};
`endif

  always_comb begin
    state_nxt      = state;
    sec_cnt_nxt    = sec_cnt;
    beep_phase_nxt = beep_phase;
`ifdef ALARM_SNOOZE_EN
    snooze_left_nxt = snooze_left;
`endif
    if (!alarm_enable) begin
      state_nxt      = ST_IDLE;
      beep_phase_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            state_nxt      = ST_RINGING;
            sec_cnt_nxt    = RING_LOAD;
            beep_phase_nxt = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snooze_left_nxt = SNOOZE_MAX;
`endif
          end
        end

        ST_RINGING: begin
          if (stop_pulse) begin
            state_nxt      = ST_IDLE;
            beep_phase_nxt = 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_ok) begin
            state_nxt       = ST_SNOOZE;
            sec_cnt_nxt     = SNOOZE_LOAD;
            beep_phase_nxt  = 1'b0;
            snooze_left_nxt = snooze_left - 3'd1;
          end
`endif
          else if (tick_1hz) begin
            sec_cnt_nxt = sec_cnt_dec;
            if (last_tick) begin
              state_nxt      = ST_IDLE;
              beep_phase_nxt = 1'b0;
            end else begin
              beep_phase_nxt = !beep_phase;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_pulse) begin
            state_nxt      = ST_IDLE;
            beep_phase_nxt = 1'b0;
          end else if (tick_1hz) begin
            if (last_tick) begin
              state_nxt      = ST_RINGING;
              sec_cnt_nxt    = RING_LOAD;
              beep_phase_nxt = 1'b1;
            end else begin
              sec_cnt_nxt = sec_cnt_dec;
            end
          end
        end
`endif

        default: begin
          state_nxt      = ST_IDLE;
          beep_phase_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sec_cnt    <= 9'd0;
      beep_phase <= 1'b0;
      match_q    <= 1'b0;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sec_cnt    <= sec_cnt_nxt;
      beep_phase <= beep_phase_nxt;
      match_q    <= match;
      ringing    <= (state_nxt == ST_RINGING);
      buzzer     <= (state_nxt == ST_RINGING) && beep_phase_nxt;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoozing    <= 1'b0;
      snooze_left <= 3'd0;
    end else begin
      snoozing    <= (state_nxt == ST_SNOOZE);
      snooze_left <= snooze_left_nxt;
    end
  end
`else
  assign snoozing    = 1'b0;
  assign snooze_left = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// -----------------------------------------------------------------------------
// tb_alarm_trigger
//
// Directed bench for alarm_trigger. It uses short ring and snooze periods:
// RING=4, SNOOZE=3, MAX_SNOOZE=2. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point, which is clear of the active edge.
// Snooze-specific steps follow the ALARM_SNOOZE_EN build setting.
// -----------------------------------------------------------------------------
module tb_alarm_trigger;

  localparam int RING   = 4;
  localparam int SNOOZE = 3;
  localparam int MAXSN  = 2;

  // clock / reset
  logic        clk;
  logic        rst_n;
  logic        tick_1hz;
  logic [23:0] current_time;
  logic [23:0] intended_alarm;
  logic        alarm_enable;
  logic        snooze_pulse;
  logic        stop_pulse;
  logic        buzzer;
  logic        ringing;
  logic        snoozing;
  logic [2:0]  snooze_left;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alarm_trigger #(
    .RING_SECONDS  (RING),
    .SNOOZE_SECONDS(SNOOZE),
    .MAX_SNOOZE    (MAXSN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1hz      (tick_1hz),
    .current_time  (current_time),
    .intended_alarm(intended_alarm),
    .alarm_enable  (alarm_enable),
    .snooze_pulse  (snooze_pulse),
    .stop_pulse    (stop_pulse),
    .buzzer        (buzzer),
    .ringing       (ringing),
    .snoozing      (snoozing),
    .snooze_left   (snooze_left)
  );

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic do_stop();
    stop_pulse = 1'b1;
    step();
    stop_pulse = 1'b0;
  endtask

  task automatic do_snooze();
    snooze_pulse = 1'b1;
    step();
    snooze_pulse = 1'b0;
  endtask

  // Walk the clock up to the alarm time so that a fresh equality episode starts.
  task automatic fire_alarm();
    current_time = 24'h072959;
    step();
    current_time = 24'h073000;
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    tick_1hz       = 1'b0;
    current_time   = 24'h000000;
    intended_alarm = 24'h000000;
    alarm_enable   = 1'b0;
    snooze_pulse   = 1'b0;
    stop_pulse     = 1'b0;

    // reset state
    steps(2);
    check("rst_ringing", 32'(ringing), 0);
    check("rst_buzzer", 32'(buzzer), 0);
    check("rst_snoozing", 32'(snoozing), 0);
    check("rst_snooze_left", 32'(snooze_left), 0);
    rst_n = 1'b1;
    step();

    // fire on equality, once per episode
    intended_alarm = 24'h073000;
    alarm_enable   = 1'b1;
    current_time   = 24'h072959;
    step();
    check("fire_before", 32'(ringing), 0);
    current_time = 24'h073000;
    step();
    check("fire_ringing", 32'(ringing), 1);
    check("fire_buzzer", 32'(buzzer), 1);
`ifdef ALARM_SNOOZE_EN
    check("fire_snooze_left", 32'(snooze_left), MAXSN);
`else
    check("fire_snooze_left", 32'(snooze_left), 0);
`endif
    do_stop();
    check("stop_ringing", 32'(ringing), 0);
    check("stop_buzzer", 32'(buzzer), 0);
    steps(3);
    check("no_refire", 32'(ringing), 0);

    // timeout after RING ticks, buzzer 1,0,1,0
    fire_alarm();
    check("to_buzzer0", 32'(buzzer), 1);
    do_tick();
    check("to_buzzer1", 32'(buzzer), 0);
    check("to_ringing1", 32'(ringing), 1);
    steps(2);
    do_tick();
    check("to_buzzer2", 32'(buzzer), 1);
    do_tick();
    check("to_buzzer3", 32'(buzzer), 0);
    check("to_sec_cnt3", 32'(dut.sec_cnt), 1);
    do_tick();
    check("to_ringing_end", 32'(ringing), 0);
    check("to_buzzer_end", 32'(buzzer), 0);

    // priority: tick + stop -> IDLE, sec_cnt untouched
    fire_alarm();
    do_tick();
    check("pr_sec_after_tick", 32'(dut.sec_cnt), 3);
    tick_1hz   = 1'b1;
    stop_pulse = 1'b1;
    step();
    tick_1hz   = 1'b0;
    stop_pulse = 1'b0;
    check("pr_tickstop_ringing", 32'(ringing), 0);
    check("pr_tickstop_sec", 32'(dut.sec_cnt), 3);

    // priority: snooze + stop -> IDLE
    fire_alarm();
    snooze_pulse = 1'b1;
    stop_pulse   = 1'b1;
    step();
    snooze_pulse = 1'b0;
    stop_pulse   = 1'b0;
    check("pr_snzstop_ringing", 32'(ringing), 0);
    check("pr_snzstop_snoozing", 32'(snoozing), 0);

`ifdef ALARM_SNOOZE_EN
    // snooze chain
    fire_alarm();
    do_snooze();
    check("sn1_snoozing", 32'(snoozing), 1);
    check("sn1_ringing", 32'(ringing), 0);
    check("sn1_buzzer", 32'(buzzer), 0);
    check("sn1_left", 32'(snooze_left), 1);
    do_tick();
    do_tick();
    check("sn1_still", 32'(snoozing), 1);
    do_tick();
    check("sn1_back_ringing", 32'(ringing), 1);
    check("sn1_back_buzzer", 32'(buzzer), 1);
    check("sn1_back_snoozing", 32'(snoozing), 0);
    do_snooze();
    check("sn2_left", 32'(snooze_left), 0);
    check("sn2_snoozing", 32'(snoozing), 1);
    do_tick();
    do_tick();
    do_tick();
    check("sn2_back_ringing", 32'(ringing), 1);
    do_snooze();
    check("sn3_ignored_ringing", 32'(ringing), 1);
    check("sn3_ignored_snoozing", 32'(snoozing), 0);
    check("sn3_left", 32'(snooze_left), 0);
    do_stop();
    check("sn_stop_ringing", 32'(ringing), 0);

    // enable dropped in SNOOZE
    fire_alarm();
    do_snooze();
    check("en_snoozing", 32'(snoozing), 1);
    alarm_enable = 1'b0;
    step();
    check("en_drop_snoozing", 32'(snoozing), 0);
    check("en_drop_ringing", 32'(ringing), 0);
`else
    // snooze ignored without the feature
    fire_alarm();
    do_snooze();
    check("nosn_ringing", 32'(ringing), 1);
    check("nosn_snoozing", 32'(snoozing), 0);
    check("nosn_buzzer", 32'(buzzer), 1);
    alarm_enable = 1'b0;
    step();
    check("en_drop_ringing", 32'(ringing), 0);
    check("en_drop_buzzer", 32'(buzzer), 0);
`endif
    current_time = 24'h080000;
    step();
    alarm_enable = 1'b1;

    // cancelled alarm never rings
    intended_alarm = 24'h000000;
    current_time   = 24'h235959;
    step();
    current_time = 24'h000000;
    steps(3);
    do_tick();
    check("cancel_ringing", 32'(ringing), 0);
    check("cancel_buzzer", 32'(buzzer), 0);

    // async reset mid-RINGING, then fire at release
    intended_alarm = 24'h073000;
    fire_alarm();
    check("pre_rst_ringing", 32'(ringing), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ringing", 32'(ringing), 0);
    check("async_rst_buzzer", 32'(buzzer), 0);
    check("async_rst_left", 32'(snooze_left), 0);
    step();
    rst_n = 1'b1;
    step();
    check("release_fire", 32'(ringing), 1);
    do_stop();
    check("final_stop", 32'(ringing), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
